// File: rtl/harris_corner_sequencer_pkg.sv
// Shared types for the Harris corner sequencer: FSM states, corner coordinates.
// No logic; combinational helper only. No flow control.
package harris_corner_sequencer_pkg;

    localparam int COORD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } corner_t;

    // A window at raster position pos is reported at its centre pixel.
    function automatic logic [COORD_W-1:0] win_center(input logic [COORD_W-1:0] pos,
                                                      input int win);
        return pos + COORD_W'(win / 2);
    endfunction

endpackage

// File: rtl/harris_corner_sequencer_if.sv
// Score-in / corner-out bundle of the Harris corner sequencer (corner_count with HARRIS_CORNER_COUNT_EN).
// Pure wiring, no latency. Corner stream is valid/ready; score stream has no backpressure.
interface harris_corner_sequencer_if
    import harris_corner_sequencer_pkg::*;
#(
    parameter int SCORE_W = 64
);

    logic                      start;
    logic signed [SCORE_W-1:0] threshold;
    logic                      score_valid;
    logic signed [SCORE_W-1:0] score;
    logic                      corner_valid;
    logic                      corner_ready;
    logic [COORD_W-1:0]        corner_x;
    logic [COORD_W-1:0]        corner_y;
    logic                      busy;
    logic                      frame_done;
    logic                      overflow;

`ifdef HARRIS_CORNER_COUNT_EN
    logic [15:0]               corner_count;

    modport master (
        output start, threshold, score_valid, score, corner_ready,
        input  corner_valid, corner_x, corner_y, busy, frame_done, overflow, corner_count
    );

    modport slave (
        input  start, threshold, score_valid, score, corner_ready,
        output corner_valid, corner_x, corner_y, busy, frame_done, overflow, corner_count
    );
`else
    modport master (
        output start, threshold, score_valid, score, corner_ready,
        input  corner_valid, corner_x, corner_y, busy, frame_done, overflow
    );

    modport slave (
        input  start, threshold, score_valid, score, corner_ready,
        output corner_valid, corner_x, corner_y, busy, frame_done, overflow
    );
`endif

endinterface

// File: rtl/harris_corner_sequencer_corner_fifo.sv
// First-word-fall-through FIFO of corner entries with full/empty flags.
// Push visible at head one cycle later; push when full is ignored unless a pop happens the same cycle.
module harris_corner_sequencer_corner_fifo
    import harris_corner_sequencer_pkg::*;
#(
    parameter int  DEPTH  = 16,
    parameter type data_t = corner_t
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  data_t push_dat,
    input  logic  pop,
    output data_t head_dat,
    output logic  full,
    output logic  empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

    data_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    data_t          last_q;
    logic           do_pop;
    logic           do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // When drained, the head keeps showing the most recently consumed entry.
    assign head_dat = empty ? last_q : mem[rd_ptr];

endmodule

// File: rtl/harris_corner_sequencer.sv
// Frame sequencer: raster-tracks Harris scores, thresholds them, queues corners (HARRIS_CORNER_COUNT_EN adds corner_count).
// Score accepted in cycle N shows at corner_valid in N+1. Corner output is valid/ready; full FIFO drops and flags overflow.
module harris_corner_sequencer
    import harris_corner_sequencer_pkg::*;
#(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int WIN        = 6,
    parameter int SCORE_W    = 64,
    parameter int FIFO_DEPTH = 16
) (
    input logic                        clk,
    input logic                        reset,
    harris_corner_sequencer_if.slave   bus
);

    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - WIN);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - WIN);

    seq_state_t                state_q;
    seq_state_t                state_d;
    logic [COORD_W-1:0]        col_q;
    logic [COORD_W-1:0]        row_q;
    logic signed [SCORE_W-1:0] thr_q;
    logic                      overflow_q;

    logic    start_acc;
    logic    score_acc;
    logic    last_score;
    logic    hit;
    logic    pop;
    logic    drop;
    corner_t push_dat;
    corner_t head_dat;
    logic    fifo_full;
    logic    fifo_empty;

    assign start_acc  = (state_q == IDLE) && bus.start;
    assign score_acc  = (state_q == RUN) && bus.score_valid;
    assign last_score = score_acc && (col_q == LAST_COL) && (row_q == LAST_ROW);
    assign hit        = score_acc && ($signed(bus.score) > $signed(thr_q));
    assign pop        = !fifo_empty && bus.corner_ready;
    assign drop       = hit && fifo_full && !pop;

    assign push_dat.x = win_center(col_q, WIN);
    assign push_dat.y = win_center(row_q, WIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start)   state_d = RUN;
            RUN:     if (last_score)  state_d = DRAIN;
            DRAIN:   if (fifo_empty)  state_d = DONE;
            DONE:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q      <= '0;
            row_q      <= '0;
            thr_q      <= '0;
            overflow_q <= 1'b0;
        end else if (start_acc) begin
            col_q      <= '0;
            row_q      <= '0;
            thr_q      <= bus.threshold;
            overflow_q <= 1'b0;
        end else begin
            if (score_acc) begin
                if (col_q == LAST_COL) begin
                    col_q <= '0;
                    row_q <= row_q + COORD_W'(1);
                end else begin
                    col_q <= col_q + COORD_W'(1);
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    harris_corner_sequencer_corner_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .data_t (corner_t)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (hit),
        .push_dat (push_dat),
        .pop      (bus.corner_ready),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef HARRIS_CORNER_COUNT_EN
    logic [15:0] count_q;

    // Dropped corners still count: this reflects detections, not deliveries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (start_acc) begin
            count_q <= '0;
        end else if (hit && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign bus.corner_count = count_q;
`endif

    assign bus.corner_valid = !fifo_empty;
    assign bus.corner_x     = head_dat.x;
    assign bus.corner_y     = head_dat.y;
    assign bus.busy         = (state_q == RUN) || (state_q == DRAIN);
    assign bus.frame_done   = (state_q == DONE);
    assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_harris_corner_sequencer.sv
// Bench for harris_corner_sequencer on a 3x3-window image with a 2-entry corner FIFO.
module tb_harris_corner_sequencer;

    localparam int IMG_W   = 8;
    localparam int IMG_H   = 8;
    localparam int WIN     = 6;
    localparam int SCORE_W = 64;
    localparam int DEPTH   = 2;
    localparam int NCOL    = IMG_W - WIN + 1;
    localparam int NWIN    = NCOL * (IMG_H - WIN + 1);

    // Frame lifecycle as seen from outside: waiting, taking scores, emptying, reporting done.
    localparam int P_IDLE    = 0;
    localparam int P_SCORING = 1;
    localparam int P_EMPTY   = 2;
    localparam int P_DONE    = 3;

    logic clk = 1'b0;
    logic reset;

    harris_corner_sequencer_if #(.SCORE_W(SCORE_W)) bus ();

    harris_corner_sequencer #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .WIN        (WIN),
        .SCORE_W    (SCORE_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct { int x; int y; } pt_t;

    pt_t    q[$];
    int     last_x, last_y;
    int     phase;
    int     m_seen;
    longint m_thr;
    bit     m_ovf;
    int     m_cnt;

    longint sc_tab [NWIN];
    bit     rdy_tab[NWIN];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_x = 0;
        last_y = 0;
        phase  = P_IDLE;
        m_seen = 0;
        m_thr  = 0;
        m_ovf  = 0;
        m_cnt  = 0;
    endtask

    task automatic check_outputs();
        chk("corner_valid", bus.corner_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("corner_x", bus.corner_x, q[0].x);
            chk("corner_y", bus.corner_y, q[0].y);
        end else begin
            chk("corner_x_hold", bus.corner_x, last_x);
            chk("corner_y_hold", bus.corner_y, last_y);
        end
        chk("busy", bus.busy, (phase == P_SCORING) || (phase == P_EMPTY));
        chk("frame_done", bus.frame_done, phase == P_DONE);
        chk("overflow", bus.overflow, m_ovf);
`ifdef HARRIS_CORNER_COUNT_EN
        chk("corner_count", bus.corner_count, m_cnt);
`endif
    endtask

    // What one clock edge does to the frame, given the inputs held during that cycle.
    task automatic model_edge(input bit st, input longint thr, input bit sv,
                              input longint sc, input bit rdy);
        bit  pop;
        bit  push;
        pt_t p;
        pop  = (q.size() > 0) && rdy;
        push = 0;
        p.x  = 0;
        p.y  = 0;
        case (phase)
            P_IDLE: if (st) begin
                m_thr  = thr;
                m_seen = 0;
                m_ovf  = 0;
                m_cnt  = 0;
                phase  = P_SCORING;
            end
            P_SCORING: if (sv) begin
                p.x = (m_seen % NCOL) + WIN / 2;
                p.y = (m_seen / NCOL) + WIN / 2;
                if (sc > m_thr) begin
                    if (m_cnt < 65535) m_cnt++;
                    if ((q.size() < DEPTH) || pop) push = 1;
                    else m_ovf = 1;
                end
                m_seen++;
                if (m_seen == NWIN) phase = P_EMPTY;
            end
            P_EMPTY: if (q.size() == 0) phase = P_DONE;
            default: phase = P_IDLE;
        endcase
        if (pop) begin
            last_x = q[0].x;
            last_y = q[0].y;
            void'(q.pop_front());
        end
        if (push) q.push_back(p);
    endtask

    task automatic step(input bit st, input longint thr, input bit sv,
                        input longint sc, input bit rdy);
        check_outputs();
        bus.start        = st;
        bus.threshold    = thr;
        bus.score_valid  = sv;
        bus.score        = sc;
        bus.corner_ready = rdy;
        model_edge(st, thr, sv, sc, rdy);
        @(posedge clk);
        #1;
    endtask

    function automatic longint rnd64();
        return longint'({$urandom, $urandom});
    endfunction

    // One frame: start, NWIN scores (with random gaps), then empty the FIFO.
    task automatic frame(input longint thr, input int gap_pct, input bit rand_rdy,
                         input int drain_hold);
        int k;
        int guard;
        bit sv;
        bit r;
        k = 0;
        guard = 0;
        step(1'b1, thr, 1'b0, 0, rand_rdy ? 1'($urandom_range(1)) : 1'b0);
        while (k < NWIN && guard < 400) begin
            sv = ($urandom_range(99) >= gap_pct);
            r  = rand_rdy ? 1'($urandom_range(1)) : rdy_tab[k];
            step(1'($urandom_range(1)), rnd64(), sv, sv ? sc_tab[k] : rnd64(), r);
            if (sv) k++;
            guard++;
        end
        guard = 0;
        while (phase != P_IDLE && guard < 200) begin
            r = rand_rdy ? 1'($urandom_range(1)) : (guard >= drain_hold);
            step(1'($urandom_range(1)), rnd64(), 1'($urandom_range(1)), rnd64(), r);
            guard++;
        end
        if (phase != P_IDLE) begin
            failures++;
            $error("FAIL frame_timeout: frame still open after %0d drain cycles, expected closed", guard);
        end
    endtask

    task automatic fill_tabs(input longint sc, input bit rdy);
        for (int i = 0; i < NWIN; i++) begin
            sc_tab[i]  = sc;
            rdy_tab[i] = rdy;
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.threshold    = '0;
        bus.score_valid  = 1'b0;
        bus.score        = '0;
        bus.corner_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;

        // All scores below threshold: nothing queued, a clean done pulse.
        fill_tabs(0, 1'b1);
        frame(100, 0, 1'b0, 0);

        // Single corner in the middle window.
        fill_tabs(0, 1'b0);
        sc_tab[4] = 101;
        frame(100, 0, 1'b0, 0);

        // Equality is not a corner.
        fill_tabs(0, 1'b1);
        sc_tab[0] = 100;
        frame(100, 0, 1'b0, 0);

        // Negative threshold, signed compare.
        fill_tabs(-20, 1'b1);
        sc_tab[0] = -5;
        frame(-10, 0, 1'b0, 0);

        // Every window a corner, consumer stalled: overflow and a long drain.
        fill_tabs(1000, 1'b0);
        frame(0, 0, 1'b0, 8);

        // Full FIFO with pop and push in the same cycle: no overflow.
        fill_tabs(0, 1'b1);
        sc_tab[0]  = 500;
        sc_tab[1]  = 500;
        sc_tab[2]  = 500;
        rdy_tab[0] = 1'b0;
        rdy_tab[1] = 1'b0;
        frame(0, 0, 1'b0, 0);

        // Ignored traffic while idle.
        for (int i = 0; i < 3; i++) step(1'b0, rnd64(), 1'b1, rnd64(), 1'($urandom_range(1)));

        // Reset in the middle of a frame.
        step(1'b1, -1000, 1'b0, 0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1, 5, 1'b0);
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;
        fill_tabs(0, 1'b1);
        sc_tab[0] = 50;
        frame(10, 0, 1'b0, 0);

        // Randomized frames with gaps, random consumer, random stray starts.
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NWIN; i++) sc_tab[i] = longint'($urandom_range(200)) - 100;
            frame(longint'($urandom_range(100)) - 50, 30, 1'b1, 0);
            step(1'b0, rnd64(), 1'($urandom_range(1)), rnd64(), 1'($urandom_range(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
